// File: rtl/myrisc_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// the load start marker and the instruction memory geometry.
package myrisc_load_ctrl_pkg;

    // Instruction memory is addressed by 8-bit word addresses.
    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 16;

    // Byte that opens a load frame; it also restarts a load from RUN.
    localparam logic [7:0] LOAD_START_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        CSUM  = 3'd4,
        RUN   = 3'd5
    } load_state_t;

    // States in which the loader is waiting for the next frame byte and
    // the inter-byte timeout is therefore armed.
    function automatic logic is_loading(input load_state_t state);
        return (state == COUNT) || (state == HI) || (state == LO) || (state == CSUM);
    endfunction

endpackage

// File: rtl/myrisc_load_ctrl_if.sv
// Bus bundle between the loader controller and its environment: the byte
// loader, the core fetch port and the instruction RAM port.
interface myrisc_load_ctrl_if;
    import myrisc_load_ctrl_pkg::*;

    // Loader byte stream.
    logic                   in_byte_valid;
    logic [7:0]             in_byte_data;
    // Core fetch request.
    logic                   in_fetch_req;
    logic [IMEM_ADDR_W-1:0] in_fetch_addr;
    // Instruction RAM.
    logic [IMEM_DATA_W-1:0] in_mem_rdata;
    logic [IMEM_ADDR_W-1:0] out_mem_addr;
    logic                   out_mem_we;
    logic [IMEM_DATA_W-1:0] out_mem_wdata;
    // Core fetch response and control.
    logic                   out_fetch_ack;
    logic [IMEM_DATA_W-1:0] out_fetch_data;
    logic                   out_core_run;
    logic                   out_load_error;

    // Environment side: loader, core and RAM drive the in_* signals.
    modport master (
        output in_byte_valid, in_byte_data, in_fetch_req, in_fetch_addr, in_mem_rdata,
        input  out_mem_addr, out_mem_we, out_mem_wdata,
        input  out_fetch_ack, out_fetch_data, out_core_run, out_load_error
    );

    // Controller side.
    modport slave (
        input  in_byte_valid, in_byte_data, in_fetch_req, in_fetch_addr, in_mem_rdata,
        output out_mem_addr, out_mem_we, out_mem_wdata,
        output out_fetch_ack, out_fetch_data, out_core_run, out_load_error
    );

endinterface

// File: rtl/myrisc_load_timeout.sv
// Loadable down-counter that flags a run of TIMEOUT_CYCLES consecutive
// counting cycles. Reloading on every frame byte makes it an inter-byte
// idle timer.
module myrisc_load_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic in_clock,
    input  logic in_reset,
    input  logic load,      // reload to TIMEOUT_CYCLES
    input  logic tick,      // count one idle cycle
    output logic expired    // this tick is the TIMEOUT_CYCLES-th in a row
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Reload takes priority; otherwise count down and hold at zero.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // The last allowed idle cycle is the one that sees a count of one.
    assign expired = tick && !load && (count == CNT_W'(1));

endmodule

// File: rtl/myrisc_load_ctrl.sv
// Instruction-memory loader and fetch front end. Receives a framed byte
// stream (A5, count, hi/lo word pairs, XOR checksum), writes the words into
// the instruction RAM while the core is held, then releases the core and
// serves its fetches from the same RAM port.
module myrisc_load_ctrl
    import myrisc_load_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic               in_clock,
    input logic               in_reset,
    myrisc_load_ctrl_if.slave bus
);

    load_state_t state, next_state;

    // Frame datapath.
    logic [7:0]             words_left;   // 0 encodes 256 words
    logic [IMEM_ADDR_W-1:0] wr_addr;      // next word address to write
    logic [7:0]             hi_byte;
    logic [7:0]             csum;

    // Registered RAM write port and fetch response.
    logic                   we_q;
    logic [IMEM_ADDR_W-1:0] waddr_q;
    logic [IMEM_DATA_W-1:0] wdata_q;
    logic                   ack_q;
    logic                   core_run_q;
    logic                   load_error_q;

    // FSM strobes.
    logic start_load;
    logic take_count;
    logic take_hi;
    logic take_lo;
    logic set_error;
    logic fetch_accept;

    logic byte_start;
    logic timer_load;
    logic timer_tick;
    logic timer_expired;

    assign byte_start = bus.in_byte_valid && (bus.in_byte_data == LOAD_START_BYTE);

    // Any byte, or being outside a frame, rearms the idle timer.
    assign timer_load = bus.in_byte_valid || !is_loading(state);
    assign timer_tick = !timer_load;

    myrisc_load_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .load     (timer_load),
        .tick     (timer_tick),
        .expired  (timer_expired)
    );

    // State register.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state <= IDLE;
        end else begin
            // NOTE: every clocked register uses non-blocking assignment so all
            // flops update together from pre-edge values.
            state <= next_state;
        end
    end

    // Next-state and per-cycle strobes for the frame parser and fetch port.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        next_state   = state;
        start_load   = 1'b0;
        take_count   = 1'b0;
        take_hi      = 1'b0;
        take_lo      = 1'b0;
        set_error    = 1'b0;
        fetch_accept = 1'b0;

        unique case (state)
            IDLE: begin
                if (byte_start) begin
                    start_load = 1'b1;
                    next_state = COUNT;
                end
            end
            COUNT: begin
                if (bus.in_byte_valid) begin
                    take_count = 1'b1;
                    next_state = HI;
                end
            end
            HI: begin
                if (bus.in_byte_valid) begin
                    take_hi    = 1'b1;
                    next_state = LO;
                end
            end
            LO: begin
                if (bus.in_byte_valid) begin
                    take_lo    = 1'b1;
                    next_state = (words_left == 8'd1) ? CSUM : HI;
                end
            end
            CSUM: begin
                if (bus.in_byte_valid) begin
                    if (bus.in_byte_data == csum) begin
                        next_state = RUN;
                    end else begin
                        set_error  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            RUN: begin
                // A restart marker wins over a fetch in the same cycle.
                if (byte_start) begin
                    start_load = 1'b1;
                    next_state = COUNT;
                end else if (bus.in_fetch_req) begin
                    fetch_accept = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // A stalled frame is abandoned from any loading state.
        if (timer_expired) begin
            set_error  = 1'b1;
            next_state = IDLE;
        end
    end

    // Frame datapath: word count, write address, high byte and checksum.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            words_left <= '0;
            wr_addr    <= '0;
            hi_byte    <= '0;
            csum       <= '0;
        end else begin
            if (take_count) begin
                words_left <= bus.in_byte_data;
                wr_addr    <= '0;
            end else if (take_lo) begin
                words_left <= words_left - 8'd1;
                wr_addr    <= wr_addr + IMEM_ADDR_W'(1);
            end

            if (take_hi) begin
                hi_byte <= bus.in_byte_data;
            end

            if (start_load) begin
                csum <= '0;
            end else if (take_hi || take_lo) begin
                csum <= csum ^ bus.in_byte_data;
            end
        end
    end

    // RAM write strobe: one cycle after each low byte, carrying the
    // address that was current when the word completed.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= take_lo;
            if (take_lo) begin
                waddr_q <= wr_addr;
                wdata_q <= {hi_byte, bus.in_byte_data};
            end
        end
    end

    // Core release, fetch acknowledge and sticky error flag.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            ack_q        <= 1'b0;
            core_run_q   <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            ack_q      <= fetch_accept;
            core_run_q <= (next_state == RUN);
            if (set_error) begin
                load_error_q <= 1'b1;
            end else if (start_load) begin
                load_error_q <= 1'b0;
            end
        end
    end

    // In RUN the core owns the RAM address; otherwise the loader does.
    assign bus.out_mem_addr   = (state == RUN) ? bus.in_fetch_addr : waddr_q;
    assign bus.out_mem_we     = we_q;
    assign bus.out_mem_wdata  = wdata_q;
    // RAM read data arrives in the cycle after the address, i.e. with the ack.
    assign bus.out_fetch_ack  = ack_q;
    assign bus.out_fetch_data = ack_q ? bus.in_mem_rdata : '0;
    assign bus.out_core_run   = core_run_q;
    assign bus.out_load_error = load_error_q;

endmodule

// File: doc/myrisc_load_ctrl.md
MYRISC_LOAD_CTRL -- requirements
Module: myrisc_load_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535: idle cycles between loader bytes before a load aborts.
REQ-002 SHALL have port in_clock, input, 1: clock; all logic on the rising edge.
REQ-003 SHALL have port in_reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_byte_valid, input, 1: loader byte strobe, one cycle per byte.
REQ-005 SHALL have port in_byte_data, input, 8: loader byte.
REQ-006 SHALL have port in_fetch_req, input, 1: core instruction fetch request.
REQ-007 SHALL have port in_fetch_addr, input, 8: core fetch word address.
REQ-008 SHALL have port in_mem_rdata, input, 16: instruction RAM read data, valid one cycle after the address.
REQ-009 SHALL have port out_mem_addr, output, 8: instruction RAM address.
REQ-010 SHALL have port out_mem_we, output, 1: instruction RAM write enable.
REQ-011 SHALL have port out_mem_wdata, output, 16: instruction RAM write data.
REQ-012 SHALL have port out_fetch_ack, output, 1: fetch data valid.
REQ-013 SHALL have port out_fetch_data, output, 16: fetched instruction.
REQ-014 SHALL have port out_core_run, output, 1: core released; 0 holds the core in reset.
REQ-015 SHALL have port out_load_error, output, 1: sticky load failure flag.

Function
REQ-016 SHALL implement states IDLE, COUNT, HI, LO, CSUM and RUN.
REQ-017 IDLE: byte 0xA5 SHALL go to COUNT, clear out_load_error and clear the checksum; other bytes SHALL be ignored.
REQ-018 COUNT: the byte SHALL latch word count N, where 0 means 256; the write address SHALL be set to 0; next state HI.
REQ-019 HI: the byte SHALL latch data[15:8]; next state LO.
REQ-020 LO: the cycle after the byte SHALL assert out_mem_we for exactly 1 cycle, with out_mem_addr = write address and out_mem_wdata = {hi, lo}.
REQ-021 LO: the write address SHALL then increment (8-bit); next state SHALL be HI while words remain, otherwise CSUM.
REQ-022 The checksum SHALL be the 8-bit XOR of every byte after the count byte, up to and including the last data byte.
REQ-023 CSUM: if the byte equals the checksum, next state SHALL be RUN; otherwise next state SHALL be IDLE and out_load_error SHALL be set.
REQ-024 In COUNT, HI, LO and CSUM, TIMEOUT_CYCLES consecutive cycles without in_byte_valid SHALL force IDLE and set out_load_error.
REQ-025 out_core_run SHALL be 1 only in RUN, registered, rising the cycle after entry to RUN.
REQ-026 RUN: when in_fetch_req=1, out_mem_addr SHALL equal in_fetch_addr combinationally.
REQ-027 RUN: the next cycle SHALL give out_fetch_ack=1 with out_fetch_data=in_mem_rdata, so fetch latency is 1 cycle and back-to-back fetches are allowed.
REQ-028 RUN: byte 0xA5 SHALL win over a same-cycle fetch; that fetch SHALL get no ack, out_core_run SHALL drop next cycle, and the state SHALL go to COUNT.
REQ-029 RUN: bytes other than 0xA5 SHALL be ignored.
REQ-030 out_fetch_ack SHALL never assert outside RUN, or in the cycle after leaving RUN.
REQ-031 out_mem_we SHALL never assert in RUN.

Reset
REQ-032 in_reset SHALL force IDLE, with out_core_run, out_mem_we, out_fetch_ack and out_load_error = 0, out_fetch_data = 0, and counters and checksum = 0.
REQ-033 Reset mid-load SHALL abandon the load with no further RAM write; RAM contents are undefined.

Structure
REQ-034 The shared package SHALL hold the state enum, LOAD_START_BYTE=0xA5 and the IMEM address width (8).
REQ-035 One sub-module, myrisc_load_timeout (loadable down-counter with expire output), SHALL be used.

Verification
REQ-036 Stream A5,02,6C,00,44,00,checksum 28 -> writes 0x6C00@0 and 0x4400@1, out_core_run=1, out_load_error=0.
REQ-037 Same stream with checksum 29 -> no run, out_load_error=1; a following valid stream clears the flag and runs.
REQ-038 RUN with fetch addr 0 then 1 on consecutive cycles -> acks on the next two cycles with data 0x6C00 and 0x4400.
REQ-039 A5 and fetch_req in the same cycle while running -> no ack, out_core_run=0 next cycle, state COUNT.
REQ-040 Stop bytes after HI with TIMEOUT_CYCLES=16 -> IDLE and out_load_error=1 after 16 cycles, no RAM write.
REQ-041 Count byte 00 -> 256 words written at addresses 0..255, address wraps to 0, then CSUM.
